// File: rtl/bldc_hall_decoder_pkg.sv
// Shared BLDC hall types: hall codes, rotation direction, decoder FSM state,
// plus the helpers that turn hall codes into sector numbers and sector steps.
package bldc_hall_decoder_pkg;

  localparam int unsigned HALL_W = 3;

  // Raw {A,B,C} pin patterns; 000 and 111 cannot occur on a healthy sensor set.
  typedef enum logic [2:0] {
    HALL_INV0 = 3'b000,
    HALL_C    = 3'b001,
    HALL_B    = 3'b010,
    HALL_BC   = 3'b011,
    HALL_A    = 3'b100,
    HALL_AC   = 3'b101,
    HALL_AB   = 3'b110,
    HALL_INV7 = 3'b111
  } hall_states_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_CW    = 2'd1,
    DIR_CCW   = 2'd2,
    DIR_BRAKE = 2'd3
  } rotation_direction_t;

  typedef enum logic [1:0] {
    HD_INIT    = 2'd0,
    HD_LOCKED  = 2'd1,
    HD_RUNNING = 2'd2,
    HD_FAULT   = 2'd3
  } hall_decoder_state_t;

  function automatic logic hall_is_valid(input logic [2:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    logic [2:0] sec;
    case (code)
      3'b101:  sec = 3'd0;
      3'b100:  sec = 3'd1;
      3'b110:  sec = 3'd2;
      3'b010:  sec = 3'd3;
      3'b011:  sec = 3'd4;
      3'b001:  sec = 3'd5;
      default: sec = 3'd0;
    endcase
    return sec;
  endfunction

  // Forward distance (to - from) mod 6 for sectors 0..5; 1 is CW, 5 is CCW.
  // The 3-bit wrap adds 8 when to < from, so subtracting 2 yields the mod-6 result.
  function automatic logic [2:0] sector_step(input logic [2:0] from_sec,
                                             input logic [2:0] to_sec);
    logic [2:0] d;
    d = to_sec - from_sec;
    if (to_sec < from_sec) d = d - 3'd2;
    return d;
  endfunction

endpackage

// File: rtl/bldc_hall_decoder_filter.sv
// Two-flop synchronizer and debounce for the hall pins; accept_o strobes
// combinationally on the cycle a new code completes its stability window.
module bldc_hall_filter
  import bldc_hall_decoder_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [HALL_W-1:0] hall_i,
  output logic [HALL_W-1:0] code_o,
  output logic              accept_o
);

  localparam logic [7:0] FILTER_LIMIT = 8'(FILTER_CYCLES);

  logic [HALL_W-1:0] sync1_q, sync2_q, prev_q, accepted_q;
  logic [7:0]        count_q, count_d, count_inc;
  logic              differs;

  // A candidate counts up while it differs from the accepted code and stays unchanged.
  always_comb begin
    differs   = (sync2_q != accepted_q);
    count_inc = (sync2_q == prev_q) ? count_q + 8'd1 : 8'd1;
    accept_o  = differs && (count_inc == FILTER_LIMIT);
    if (!differs || accept_o) count_d = '0;
    else                      count_d = count_inc;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      accepted_q <= '0;
      count_q    <= '0;
    end else begin
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      count_q <= count_d;
      if (accept_o) accepted_q <= sync2_q;
    end
  end

  assign code_o = sync2_q;

endmodule

// File: rtl/bldc_hall_decoder.sv
// BLDC hall decoder: filtered hall code to sector, direction, edge period,
// and fault/skip/stall status, all registered on the acceptance edge.
module bldc_hall_decoder
  import bldc_hall_decoder_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 16,
  parameter int unsigned PERIOD_WIDTH  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              hall_in,
  output hall_states_t            hall_state,
  output logic [2:0]              sector,
  output logic                    sector_valid,
  output rotation_direction_t     dir,
  output logic                    edge_stb,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    hall_fault,
  output logic                    skip_err,
  output logic                    stall
);

  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;

  logic [2:0] filt_code;
  logic       filt_accept;

  bldc_hall_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .hall_i  (hall_in),
    .code_o  (filt_code),
    .accept_o(filt_accept)
  );

  hall_decoder_state_t     state_q;
  hall_states_t            hall_state_q;
  logic [2:0]              sector_q;
  logic                    sector_valid_q;
  rotation_direction_t     dir_q;
  logic                    edge_stb_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                    period_valid_q;
  logic                    hall_fault_q;
  logic                    skip_err_q;
  logic                    stall_q;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;

  logic       new_valid;
  logic [2:0] new_sector;
  logic [2:0] step;
  logic       adjacent;

  always_comb begin
    new_valid  = hall_is_valid(filt_code);
    new_sector = hall_to_sector(filt_code);
    step       = sector_step(sector_q, new_sector);
    adjacent   = (step == 3'd1) || (step == 3'd5);
    cnt_d      = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + PERIOD_WIDTH'(1);
  end

  // Every status output moves on the same edge the filter accepts a code,
  // so consumers never see hall_state and its derived flags disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HD_INIT;
      hall_state_q   <= HALL_INV0;
      sector_q       <= '0;
      sector_valid_q <= 1'b0;
      dir_q          <= DIR_NONE;
      edge_stb_q     <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      hall_fault_q   <= 1'b0;
      skip_err_q     <= 1'b0;
      stall_q        <= 1'b0;
      cnt_q          <= '0;
    end else begin
      edge_stb_q <= 1'b0;
      skip_err_q <= 1'b0;
      if (filt_accept) begin
        edge_stb_q   <= 1'b1;
        hall_state_q <= hall_states_t'(filt_code);
        cnt_q        <= '0;
        stall_q      <= 1'b0;
        if (!new_valid) begin
          hall_fault_q   <= 1'b1;
          sector_valid_q <= 1'b0;
          dir_q          <= DIR_NONE;
          period_valid_q <= 1'b0;
          state_q        <= HD_FAULT;
        end else begin
          hall_fault_q   <= 1'b0;
          sector_q       <= new_sector;
          sector_valid_q <= 1'b1;
          case (state_q)
            HD_LOCKED, HD_RUNNING: begin
              if (adjacent) begin
                dir_q   <= (step == 3'd1) ? DIR_CW : DIR_CCW;
                state_q <= HD_RUNNING;
                // A full period needs two adjacent edges, so only RUNNING measures it.
                if (state_q == HD_RUNNING) begin
                  period_q       <= cnt_d;
                  period_valid_q <= 1'b1;
                end
              end else begin
                skip_err_q     <= 1'b1;
                dir_q          <= DIR_NONE;
                period_valid_q <= 1'b0;
                state_q        <= HD_LOCKED;
              end
            end
            default: begin
              dir_q          <= DIR_NONE;
              period_valid_q <= 1'b0;
              state_q        <= HD_LOCKED;
            end
          endcase
        end
      end else begin
        cnt_q <= cnt_d;
        if ((state_q == HD_RUNNING) && (cnt_d == CNT_MAX)) begin
          stall_q        <= 1'b1;
          dir_q          <= DIR_NONE;
          period_valid_q <= 1'b0;
          state_q        <= HD_LOCKED;
        end
      end
    end
  end

  assign hall_state   = hall_state_q;
  assign sector       = sector_q;
  assign sector_valid = sector_valid_q;
  assign dir          = dir_q;
  assign edge_stb     = edge_stb_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign hall_fault   = hall_fault_q;
  assign skip_err     = skip_err_q;
  assign stall        = stall_q;

endmodule

// File: doc/bldc_hall_decoder.md
BLDC_HALL_DECODER -- requirements
Module: bldc_hall_decoder

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 16: consecutive stable synchronized cycles required to accept a new hall code (range 1..255).
REQ-002 SHALL have parameter PERIOD_WIDTH, default 24: width of the edge-period counter and output.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 hall_in  in  3  raw hall pins {A,B,C}, asynchronous to clk.
REQ-007 hall_state  out  hall_states_t  last accepted (filtered) hall code.
REQ-008 sector  out  3  sector 0..5 of hall_state; HALL_AC=0, HALL_A=1, HALL_AB=2, HALL_B=3, HALL_BC=4, HALL_C=5.
REQ-009 sector_valid  out  1  hall_state is one of the six valid codes.
REQ-010 dir  out  rotation_direction_t  measured direction: DIR_CW, DIR_CCW or DIR_NONE; never DIR_BRAKE.
REQ-011 edge_stb  out  1  one-cycle pulse on each accepted change of hall_state.
REQ-012 period  out  PERIOD_WIDTH  clk cycles between the last two adjacent-sector edges.
REQ-013 period_valid  out  1  period holds a valid measurement.
REQ-014 hall_fault  out  1  level: accepted code is 3'b000 or 3'b111.
REQ-015 skip_err  out  1  one-cycle pulse on a non-adjacent valid sector jump.
REQ-016 stall  out  1  level: no edge for 2^PERIOD_WIDTH-1 cycles while RUNNING.

Function
REQ-017 hall_in SHALL pass a 2-flop synchronizer, then a filter accepting a code that differs from hall_state once it has held FILTER_CYCLES consecutive cycles; any change restarts the count.
REQ-018 Latency raw pin change to hall_state/edge_stb SHALL be exactly 2+FILTER_CYCLES cycles for a clean change.
REQ-019 All outputs SHALL be registered and SHALL update on the same edge as hall_state acceptance.
REQ-020 FSM states: INIT, LOCKED, RUNNING, FAULT.
REQ-021 INIT: valid code accepted -> LOCKED; invalid code -> FAULT.
REQ-022 LOCKED: adjacent sector accepted (delta +1 mod 6 -> DIR_CW, -1 -> DIR_CCW) -> RUNNING, dir set, period_valid stays 0.
REQ-023 RUNNING: adjacent edge -> dir per delta (reversal flips dir), period <= sat(cnt+1), period_valid <= 1.
REQ-024 LOCKED/RUNNING: non-adjacent valid jump -> skip_err pulse, dir <= DIR_NONE, period_valid <= 0, -> LOCKED.
REQ-025 Any state: invalid code accepted -> hall_fault=1, sector_valid=0, dir=DIR_NONE, period_valid=0, -> FAULT; sector holds last valid value.
REQ-026 FAULT: valid code accepted -> hall_fault=0, -> LOCKED.
REQ-027 Edge counter cnt SHALL clear to 0 on every edge_stb, otherwise increment, saturating at 2^PERIOD_WIDTH-1.
REQ-028 RUNNING with cnt saturated: stall <= 1, dir <= DIR_NONE, period_valid <= 0, -> LOCKED; stall clears on next edge_stb.
REQ-029 edge_stb SHALL pulse for every accepted change, including invalid codes and skips.

Reset
REQ-030 Reset SHALL force: state INIT, synchronizer and filter 3'b000, hall_state 3'b000, sector 0, sector_valid 0, dir DIR_NONE, edge_stb 0, period 0, period_valid 0, hall_fault 0, skip_err 0, stall 0, cnt 0.
REQ-031 Reset mid-rotation SHALL discard all history; first accepted valid code after release SHALL NOT produce a direction.

Structure
REQ-032 rotation_direction_t, hall_states_t and new hall_decoder_state_t SHALL live in the shared bldc types package; sector-from-hall mapping SHALL be a package function.
REQ-033 Synchronizer plus debounce SHALL be a sub-module bldc_hall_filter (parameter FILTER_CYCLES, 3-bit in/out, accept strobe).

Verification (FILTER_CYCLES=4, PERIOD_WIDTH=8)
REQ-034 Reset release, hall_in=3'b101 held -> at cycle 6 hall_state=HALL_AC, sector=0, edge_stb=1, dir=DIR_NONE, state LOCKED.
REQ-035 CW sequence 101,100,110,010 every 20 cycles -> dir=DIR_CW from 2nd edge, period=20, period_valid=1 from 3rd edge.
REQ-036 Glitch of 3 cycles on hall_in during sector 1 -> no edge_stb, hall_state unchanged.
REQ-037 From sector 1, jump to 3'b011 -> skip_err pulse, sector=4, dir=DIR_NONE, period_valid=0; then 3'b000 held -> hall_fault=1, sector_valid=0.
REQ-038 RUNNING CW, hall_in frozen 300 cycles -> stall=1 and dir=DIR_NONE 255 cycles after last edge; CCW edge then -> stall=0, dir=DIR_CCW, period_valid=0.
